// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the 32x32 MIPS register file: zeroes r1..r31 after reset,
// then shares the single write port between write-back (A) and the MDU/load unit (B).
module regfile_wr_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_ready,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic [4:0]  Rd_addr,
  output logic [31:0] Rd_data,
  output logic        RegWrite,
  output logic        init_done
);
  typedef enum logic {CLEAR, RUN} state_e;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [3:0]  starve_q, starve_d;
  logic [4:0]  rd_addr_q;
  logic [31:0] rd_data_q;
  logic        regwrite_q, init_done_q;
  logic        grant_a, grant_b;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  // Grants depend only on valids, state and starvation count, never on ready.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == RUN) begin
      if (mdu_valid && starve_q == SMAX) grant_b = 1'b1;
      else if (wb_valid)                 grant_a = 1'b1;
      else if (mdu_valid)                grant_b = 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!mdu_valid || grant_b)  starve_d = 4'd0;
    else if (starve_q != SMAX)  starve_d = starve_q + 4'd1;
  end

  assign sel_addr = grant_b ? mdu_addr : wb_addr;
  assign sel_data = grant_b ? mdu_data : wb_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR;
      cnt_q       <= 5'd1;
      starve_q    <= 4'd0;
      rd_addr_q   <= 5'd0;
      rd_data_q   <= 32'd0;
      regwrite_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          regwrite_q <= 1'b1;
          rd_addr_q  <= cnt_q;
          rd_data_q  <= 32'd0;
          cnt_q      <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          starve_q <= starve_d;
          if (grant_a || grant_b) begin
            rd_addr_q  <= sel_addr;
            rd_data_q  <= sel_data;
            // r0 is hardwired zero: accept the request but drop the write.
            regwrite_q <= (sel_addr != 5'd0);
          end else begin
            regwrite_q <= 1'b0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign wb_ready  = grant_a;
  assign mdu_ready = grant_b;
  assign Rd_addr   = rd_addr_q;
  assign Rd_data   = rd_data_q;
  assign RegWrite  = regwrite_q;
  assign init_done = init_done_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: clear sequence, vector table, starvation,
// same-address ordering and reset during the clear sequence.
module tb_regfile_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, mdu_valid;
  logic [4:0]  wb_addr, mdu_addr;
  logic [31:0] wb_data, mdu_data;
  logic        wb_ready, mdu_ready;
  logic [4:0]  Rd_addr;
  logic [31:0] Rd_data;
  logic        RegWrite, init_done;

  int checks = 0;
  int errors = 0;
  logic [31:0] rf [32];

  regfile_wr_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .Rd_addr(Rd_addr), .Rd_data(Rd_data), .RegWrite(RegWrite), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Register file model written one edge after the registered write request.
  always @(posedge clk) if (RegWrite) rf[Rd_addr] <= Rd_data;

  typedef struct {
    logic        wv; logic [4:0] wa; logic [31:0] wd;
    logic        mv; logic [4:0] ma; logic [31:0] md;
    logic        e_wr; logic e_mr;
    logic        e_we; logic [4:0] e_addr; logic [31:0] e_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    mdu_valid = mv; mdu_addr = ma; mdu_data = md;
  endtask

  // Runs the 31-edge clear with requests pending; starts on a negedge with rst low.
  task automatic clear_seq(input string tag);
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      chk({tag, "_we"},   32'(RegWrite),  32'd1);
      chk({tag, "_addr"}, 32'(Rd_addr),   32'(i));
      chk({tag, "_data"}, Rd_data,        32'd0);
      chk({tag, "_done"}, 32'(init_done), 32'(i == 31));
      chk({tag, "_wrdy"}, 32'(wb_ready),  32'(i == 31));
      chk({tag, "_mrdy"}, 32'(mdu_ready), 32'd0);
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  vec_t vt [11];
  int   low_run, max_low;

  initial begin
    vt[0]  = '{1, 5'd5,  32'h1234_5678, 0, 5'd0,  32'h0,         1, 0, 1, 5'd5,  32'h1234_5678};
    vt[1]  = '{0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         0, 0, 0, 5'd5,  32'h1234_5678};
    vt[2]  = '{0, 5'd0,  32'h0,         1, 5'd0,  32'hFFFF_FFFF, 0, 1, 0, 5'd0,  32'hFFFF_FFFF};
    vt[3]  = '{0, 5'd0,  32'h0,         1, 5'd7,  32'h77,        0, 1, 1, 5'd7,  32'h77};
    vt[4]  = '{1, 5'd3,  32'h31,        1, 5'd10, 32'hB0B0,      1, 0, 1, 5'd3,  32'h31};
    vt[5]  = '{1, 5'd4,  32'h41,        1, 5'd10, 32'hB0B0,      1, 0, 1, 5'd4,  32'h41};
    vt[6]  = '{1, 5'd5,  32'h51,        1, 5'd10, 32'hB0B0,      1, 0, 1, 5'd5,  32'h51};
    vt[7]  = '{1, 5'd6,  32'h61,        1, 5'd10, 32'hB0B0,      1, 0, 1, 5'd6,  32'h61};
    vt[8]  = '{1, 5'd6,  32'h62,        1, 5'd10, 32'hB0B0,      0, 1, 1, 5'd10, 32'hB0B0};
    vt[9]  = '{1, 5'd2,  32'h22,        1, 5'd11, 32'hC0C0,      1, 0, 1, 5'd2,  32'h22};
    vt[10] = '{0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         0, 0, 0, 5'd2,  32'h22};

    rst = 1'b1;
    drive(1, 0, 0, 1, 0, 0);
    #2;
    chk("rst_we",   32'(RegWrite),  32'd0);
    chk("rst_addr", 32'(Rd_addr),   32'd0);
    chk("rst_data", Rd_data,        32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_wrdy", 32'(wb_ready),  32'd0);
    chk("rst_mrdy", 32'(mdu_ready), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("pre_wrdy", 32'(wb_ready), 32'd0);
    clear_seq("clr");
    @(negedge clk);
    chk("idle_we",   32'(RegWrite), 32'd0);
    chk("idle_addr", 32'(Rd_addr),  32'd31);

    // Vector table: drive at negedge, readies after settle, outputs next negedge.
    for (int v = 0; v < 11; v++) begin
      drive(vt[v].wv, vt[v].wa, vt[v].wd, vt[v].mv, vt[v].ma, vt[v].md);
      #1;
      chk($sformatf("v%0d_wrdy", v), 32'(wb_ready),  32'(vt[v].e_wr));
      chk($sformatf("v%0d_mrdy", v), 32'(mdu_ready), 32'(vt[v].e_mr));
      @(negedge clk);
      chk($sformatf("v%0d_we", v),   32'(RegWrite), 32'(vt[v].e_we));
      chk($sformatf("v%0d_addr", v), 32'(Rd_addr),  32'(vt[v].e_addr));
      chk($sformatf("v%0d_data", v), Rd_data,       vt[v].e_data);
    end

    // Both requesters held: A,A,A,A,B repeating; B never refused more than 4 cycles.
    low_run = 0; max_low = 0;
    for (int k = 0; k < 20; k++) begin
      drive(1, 5'd12, 32'(k), 1, 5'd11, 32'hBB);
      #1;
      chk("starve_wrdy", 32'(wb_ready),  32'((k % 5) != 4));
      chk("starve_mrdy", 32'(mdu_ready), 32'((k % 5) == 4));
      if (mdu_ready) low_run = 0;
      else begin low_run++; if (low_run > max_low) max_low = low_run; end
      @(negedge clk);
      chk("starve_addr", 32'(Rd_addr), ((k % 5) == 4) ? 32'd11 : 32'd12);
      chk("starve_data", Rd_data,      ((k % 5) == 4) ? 32'hBB : 32'(k));
    end
    chk("starve_maxlow", 32'(max_low), 32'd4);

    // Same address 9 with B at the starvation limit: B then A, A wins.
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'd20, 32'(k), 1, 5'd9, 32'hB);
      @(negedge clk);
    end
    drive(1, 5'd9, 32'hA, 1, 5'd9, 32'hB);
    #1;
    chk("same_mrdy", 32'(mdu_ready), 32'd1);
    chk("same_wrdy", 32'(wb_ready),  32'd0);
    @(negedge clk);
    chk("same_b_addr", 32'(Rd_addr), 32'd9);
    chk("same_b_data", Rd_data,      32'hB);
    drive(1, 5'd9, 32'hA, 0, 5'd0, 32'h0);
    #1;
    chk("same_a_wrdy", 32'(wb_ready), 32'd1);
    @(negedge clk);
    chk("same_a_we",   32'(RegWrite), 32'd1);
    chk("same_a_data", Rd_data,       32'hA);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("same_rf9", rf[9], 32'hA);

    // Reset pulse while the clear sequence sits at cnt=17.
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) @(negedge clk);
    chk("mid_addr16", 32'(Rd_addr), 32'd16);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_we",   32'(RegWrite),  32'd0);
    chk("mid_addr", 32'(Rd_addr),   32'd0);
    chk("mid_done", 32'(init_done), 32'd0);
    chk("mid_wrdy", 32'(wb_ready),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_seq("reclr");
    @(negedge clk);
    chk("end_we",   32'(RegWrite), 32'd0);
    chk("end_rf9",  rf[9],         32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
